// File: rtl/wb_trace_buffer.sv
// Wishbone transaction tracer: snoops one master port, filters acked cycles
// by address window and direction, timestamps them into a drainable FIFO.
//
// Ports:
//   clk, reset         clock and synchronous active-low reset
//   mon_*              snooped Wishbone cycle (cyc/stb/ack/we/adr/dat_w/dat_r)
//   enable             capture enable
//   filt_base/mask     address window: hit when (adr ^ base) & mask == 0
//   filt_mode          00 all, 01 reads, 10 writes, 11 none
//   stop_full          1 drops new entries when full, 0 overwrites oldest
//   clear              synchronous flush of entries and drop counter
//   out_valid/ready    valid/ready drain of the head entry
//   out_adr/dat/we/ts  head entry fields
//   count, drops       occupancy and saturating lost-entry count
module wb_trace_buffer #(
  parameter int adr_width  = 32,
  parameter int dat_width  = 32,
  parameter int depth_log2 = 4,
  parameter int ts_width   = 16,
  parameter int drop_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mon_cyc,
  input  logic                  mon_stb,
  input  logic                  mon_ack,
  input  logic                  mon_we,
  input  logic [adr_width-1:0]  mon_adr,
  input  logic [dat_width-1:0]  mon_dat_w,
  input  logic [dat_width-1:0]  mon_dat_r,
  input  logic                  enable,
  input  logic [adr_width-1:0]  filt_base,
  input  logic [adr_width-1:0]  filt_mask,
  input  logic [1:0]            filt_mode,
  input  logic                  stop_full,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [adr_width-1:0]  out_adr,
  output logic [dat_width-1:0]  out_dat,
  output logic                  out_we,
  output logic [ts_width-1:0]   out_ts,
  output logic [depth_log2:0]   count,
  output logic [drop_width-1:0] drops
);

  localparam int DEPTH = 1 << depth_log2;
  localparam int EW    = 1 + ts_width + dat_width + adr_width;

  logic [EW-1:0]         mem_q [DEPTH];
  logic [depth_log2-1:0] wr_q, wr_d;
  logic [depth_log2-1:0] rd_q, rd_d;
  logic [depth_log2:0]   count_q, count_d;
  logic [drop_width-1:0] drops_q, drops_d;
  logic [ts_width-1:0]   ts_q, ts_d;

  logic                 dir_ok;
  logic                 win_ok;
  logic                 hit;
  logic                 full;
  logic                 pop;
  logic                 mem_we;
  logic [dat_width-1:0] cap_dat;
  logic [EW-1:0]        entry;

  always_comb begin
    unique case (filt_mode)
      2'b00:   dir_ok = 1'b1;
      2'b01:   dir_ok = ~mon_we;
      2'b10:   dir_ok = mon_we;
      default: dir_ok = 1'b0;
    endcase
  end

  assign win_ok  = ((mon_adr ^ filt_base) & filt_mask) == '0;
  assign hit     = mon_cyc & mon_stb & mon_ack
                 & enable & win_ok & dir_ok;
  assign cap_dat = mon_we ? mon_dat_w : mon_dat_r;
  assign entry   = {mon_we, ts_q, cap_dat, mon_adr};

  // count never exceeds DEPTH, so its MSB alone flags full
  assign full      = count_q[depth_log2];
  assign out_valid = count_q != '0;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    drops_d = drops_q;
    mem_we  = 1'b0;
    ts_d    = ts_q + 1'b1;
    if (clear) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      drops_d = '0;
    end else begin
      // when full, wr == rd, so an overwrite lands on the oldest slot
      if (hit && (!full || pop || !stop_full)) begin
        mem_we = 1'b1;
        wr_d   = wr_q + 1'b1;
      end
      if (pop || (hit && full && !stop_full))
        rd_d = rd_q + 1'b1;
      if (hit && !full && !pop)
        count_d = count_q + 1'b1;
      else if (!hit && pop)
        count_d = count_q - 1'b1;
      if (hit && full && !pop && drops_q != '1)
        drops_d = drops_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      drops_q <= '0;
      ts_q    <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      drops_q <= drops_d;
      ts_q    <= ts_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && reset)
      mem_q[wr_q] <= entry;
  end

  assign {out_we, out_ts, out_dat, out_adr} = mem_q[rd_q];
  assign count = count_q;
  assign drops = drops_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: filter vector table plus
// directed sequences for ordering, overflow, clear, reset and timestamps.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mon_cyc, mon_stb, mon_ack, mon_we;
  logic [31:0] mon_adr, mon_dat_w, mon_dat_r;
  logic        enable;
  logic [31:0] filt_base, filt_mask;
  logic [1:0]  filt_mode;
  logic        stop_full, clear, out_ready;

  logic        out_valid, out_we;
  logic [31:0] out_adr, out_dat;
  logic [15:0] out_ts;
  logic [4:0]  count;
  logic [7:0]  drops;

  logic        t4_valid, t4_we;
  logic [31:0] t4_adr, t4_dat;
  logic [3:0]  t4_ts;
  logic [4:0]  t4_count;
  logic [7:0]  t4_drops;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  wb_trace_buffer dut (
    .clk(clk), .reset(reset),
    .mon_cyc(mon_cyc), .mon_stb(mon_stb),
    .mon_ack(mon_ack), .mon_we(mon_we),
    .mon_adr(mon_adr),
    .mon_dat_w(mon_dat_w), .mon_dat_r(mon_dat_r),
    .enable(enable),
    .filt_base(filt_base), .filt_mask(filt_mask),
    .filt_mode(filt_mode),
    .stop_full(stop_full), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_adr(out_adr), .out_dat(out_dat),
    .out_we(out_we), .out_ts(out_ts),
    .count(count), .drops(drops)
  );

  wb_trace_buffer #(.ts_width(4)) u_ts4 (
    .clk(clk), .reset(reset),
    .mon_cyc(mon_cyc), .mon_stb(mon_stb),
    .mon_ack(mon_ack), .mon_we(mon_we),
    .mon_adr(mon_adr),
    .mon_dat_w(mon_dat_w), .mon_dat_r(mon_dat_r),
    .enable(enable),
    .filt_base(filt_base), .filt_mask(filt_mask),
    .filt_mode(filt_mode),
    .stop_full(stop_full), .clear(clear),
    .out_valid(t4_valid), .out_ready(out_ready),
    .out_adr(t4_adr), .out_dat(t4_dat),
    .out_we(t4_we), .out_ts(t4_ts),
    .count(t4_count), .drops(t4_drops)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] base;
    logic [31:0] mask;
    logic [1:0]  mode;
    logic        en;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic we,
                     input logic [31:0] adr,
                     input logic [31:0] dat);
    mon_cyc   = 1'b1;
    mon_stb   = 1'b1;
    mon_ack   = 1'b1;
    mon_we    = we;
    mon_adr   = adr;
    mon_dat_w = we ? dat : ~dat;
    mon_dat_r = we ? ~dat : dat;
    tick();
  endtask

  task automatic idle();
    mon_cyc = 1'b0;
    mon_stb = 1'b0;
    mon_ack = 1'b0;
    tick();
  endtask

  task automatic flush();
    mon_cyc = 1'b0;
    mon_stb = 1'b0;
    mon_ack = 1'b0;
    clear   = 1'b1;
    tick();
    clear   = 1'b0;
  endtask

  task automatic drain(input int n, input logic [31:0] first);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_valid", 64'(out_valid), 64'(1));
      check("drain_dat", 64'(out_dat), 64'(first + i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 64'(out_valid), 64'(0));
  endtask

  initial begin
    logic [15:0] t0, t1;
    logic [15:0] p16;
    logic [3:0]  p4;
    int          wraps;

    vecs[0]  = '{0, 32'h4000_0010, 32'h4000_0000,
                 32'hF000_0000, 2'b01, 1, 1};
    vecs[1]  = '{1, 32'h4000_0010, 32'h4000_0000,
                 32'hF000_0000, 2'b01, 1, 0};
    vecs[2]  = '{0, 32'h0000_0010, 32'h4000_0000,
                 32'hF000_0000, 2'b01, 1, 0};
    vecs[3]  = '{1, 32'h4000_0010, 32'h4000_0000,
                 32'hF000_0000, 2'b10, 1, 1};
    vecs[4]  = '{0, 32'h4000_0010, 32'h4000_0000,
                 32'hF000_0000, 2'b10, 1, 0};
    vecs[5]  = '{1, 32'h4000_0010, 32'h4000_0000,
                 32'hF000_0000, 2'b00, 1, 1};
    vecs[6]  = '{0, 32'h4000_0010, 32'h4000_0000,
                 32'hF000_0000, 2'b00, 1, 1};
    vecs[7]  = '{1, 32'h4000_0010, 32'h4000_0000,
                 32'hF000_0000, 2'b11, 1, 0};
    vecs[8]  = '{1, 32'h4000_0010, 32'h4000_0000,
                 32'hF000_0000, 2'b00, 0, 0};
    vecs[9]  = '{0, 32'h1234_5678, 32'hDEAD_BEEF,
                 32'h0000_0000, 2'b00, 1, 1};
    vecs[10] = '{1, 32'h0000_1FFC, 32'h0000_1000,
                 32'hFFFF_F000, 2'b00, 1, 1};
    vecs[11] = '{1, 32'h0000_2000, 32'h0000_1000,
                 32'hFFFF_F000, 2'b00, 1, 0};

    reset = 1'b0;
    mon_cyc = 0; mon_stb = 0; mon_ack = 0; mon_we = 0;
    mon_adr = '0; mon_dat_w = '0; mon_dat_r = '0;
    enable = 1'b1; filt_base = '0; filt_mask = '0;
    filt_mode = 2'b00; stop_full = 1'b1;
    clear = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_count", 64'(count), 64'(0));
    check("rst_drops", 64'(drops), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    reset = 1'b1;

    // in-order capture and drain
    ack(1, 32'h0000_1000, 32'hA);
    ack(1, 32'h0000_1004, 32'hB);
    ack(1, 32'h0000_1008, 32'hC);
    idle();
    check("seq_count", 64'(count), 64'(3));
    check("seq_adr", 64'(out_adr), 64'h1000);
    check("seq_dat", 64'(out_dat), 64'hA);
    check("seq_we", 64'(out_we), 64'(1));
    idle();
    check("seq_hold", 64'(out_dat), 64'hA);
    drain(3, 32'hA);

    // filter vector table
    for (int i = 0; i < 12; i++) begin
      flush();
      enable    = vecs[i].en;
      filt_base = vecs[i].base;
      filt_mask = vecs[i].mask;
      filt_mode = vecs[i].mode;
      ack(vecs[i].we, vecs[i].adr, 32'h5A00 + i);
      idle();
      check($sformatf("vec%0d_count", i),
            64'(count), 64'(vecs[i].exp_hit));
      if (vecs[i].exp_hit) begin
        check($sformatf("vec%0d_dat", i),
              64'(out_dat), 64'(32'h5A00 + i));
        check($sformatf("vec%0d_adr", i),
              64'(out_adr), 64'(vecs[i].adr));
        check($sformatf("vec%0d_we", i),
              64'(out_we), 64'(vecs[i].we));
      end
    end

    // window/direction sequence
    flush();
    filt_base = 32'h4000_0000;
    filt_mask = 32'hF000_0000;
    filt_mode = 2'b01;
    ack(0, 32'h4000_0010, 32'h11);
    ack(1, 32'h4000_0010, 32'h22);
    ack(0, 32'h0000_0010, 32'h33);
    idle();
    check("filt_count", 64'(count), 64'(1));
    check("filt_dat", 64'(out_dat), 64'h11);
    enable = 1'b1; filt_base = '0;
    filt_mask = '0; filt_mode = 2'b00;

    // empty: push with ready high is stored
    flush();
    out_ready = 1'b1;
    ack(1, 32'h10, 32'h77);
    out_ready = 1'b0;
    idle();
    check("empty_pp_count", 64'(count), 64'(1));
    check("empty_pp_dat", 64'(out_dat), 64'h77);

    // stop when full
    flush();
    stop_full = 1'b1;
    for (int i = 0; i < 20; i++) ack(1, 32'h100, i);
    idle();
    check("stop_count", 64'(count), 64'(16));
    check("stop_drops", 64'(drops), 64'(4));
    drain(16, 0);

    // overwrite when full, then saturate drops
    flush();
    stop_full = 1'b0;
    for (int i = 0; i < 20; i++) ack(1, 32'h100, i);
    idle();
    check("ovw_count", 64'(count), 64'(16));
    check("ovw_drops", 64'(drops), 64'(4));
    drain(16, 4);
    for (int i = 0; i < 300; i++) ack(1, 32'h100, i);
    idle();
    check("sat_count", 64'(count), 64'(16));
    check("sat_drops", 64'(drops), 64'(255));

    // full with push and pop together
    flush();
    for (int i = 0; i < 16; i++) ack(1, 32'h200, i);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ack(1, 32'h200, 16 + k);
      check("fpp_count", 64'(count), 64'(16));
      check("fpp_drops", 64'(drops), 64'(0));
      check("fpp_head", 64'(out_dat), 64'(k + 1));
    end
    out_ready = 1'b0;
    stop_full = 1'b1;
    ack(1, 32'h200, 32'h99);
    check("pre_clr_drops", 64'(drops), 64'(1));
    clear = 1'b1;
    ack(1, 32'h200, 32'h98);
    clear = 1'b0;
    check("clr_count", 64'(count), 64'(0));
    check("clr_drops", 64'(drops), 64'(0));
    check("clr_valid", 64'(out_valid), 64'(0));
    idle();

    // timestamps 3 clocks apart
    flush();
    ack(1, 32'h300, 1);
    idle();
    idle();
    ack(1, 32'h300, 2);
    idle();
    t0 = out_ts;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    t1 = out_ts;
    check("ts_delta", 64'(t1 - t0), 64'(3));

    // streaming: head is always the latest ack
    flush();
    out_ready = 1'b1;
    wraps = 0;
    p16 = '0;
    p4 = '0;
    for (int i = 0; i < 20; i++) begin
      ack(1, 32'h400, i);
      if (i > 0) begin
        check("ts16_step", 64'(out_ts), 64'(p16 + 16'd1));
        check("ts4_step", 64'(t4_ts), 64'(4'(p4 + 4'd1)));
        if (p4 == 4'hF && t4_ts == 4'h0) wraps++;
      end
      p16 = out_ts;
      p4 = t4_ts;
    end
    out_ready = 1'b0;
    idle();
    check("ts4_wrap_seen", 64'(wraps > 0), 64'(1));

    // reset mid-operation
    flush();
    for (int i = 0; i < 5; i++) ack(1, 32'h500, i);
    idle();
    check("pre_rst_count", 64'(count), 64'(5));
    reset = 1'b0;
    clear = 1'b1;
    tick();
    reset = 1'b1;
    clear = 1'b0;
    check("mid_rst_count", 64'(count), 64'(0));
    check("mid_rst_valid", 64'(out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Synthesizable Wishbone transaction tracer for the lm32 system: it snoops one Wishbone master port (e.g. the LM32 data bus), filters completed transactions by address window and direction, and timestamps them into a parametrised FIFO. A valid/ready port drains the FIFO, for a UART dump engine or a bench. It replaces the bench-only `$display` monitor with hardware that also works on the board, adding filtering, buffering, overflow policy and drop accounting.

## Interface
- `adr_width`, 32, monitored address width
- `dat_width`, 32, monitored data width
- `depth_log2`, 4, FIFO depth is 2**depth_log2 entries
- `ts_width`, 16, timestamp counter width
- `drop_width`, 8, saturating drop-counter width

Ports:
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-low reset
- `mon_cyc`, `mon_stb`, `mon_ack`, `mon_we`  in  1 each  snooped Wishbone control
- `mon_adr`  in  adr_width  snooped address
- `mon_dat_w`, `mon_dat_r`  in  dat_width each  snooped write/read data
- `enable`  in  1  capture enable
- `filt_base`, `filt_mask`  in  adr_width each  address window
- `filt_mode`  in  2  00 all, 01 reads only, 10 writes only, 11 none
- `stop_full`  in  1  1 = drop new entries when full; 0 = overwrite oldest
- `clear`  in  1  synchronous flush
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  consumer accepts head
- `out_adr`  out  adr_width, `out_dat`  out  dat_width, `out_we`  out  1, `out_ts`  out  ts_width  head entry fields
- `count`  out  depth_log2+1  occupancy
- `drops`  out  drop_width  lost-entry counter, saturating

## Operation
- Hit: `mon_cyc & mon_stb & mon_ack & enable & ((mon_adr ^ filt_base) & filt_mask) == 0` and direction allowed by `filt_mode`. The captured data is `mon_dat_w` if `mon_we`, else `mon_dat_r`.
- Timestamp: a free-running `ts_width` counter counts +1 every clk and wraps to 0. An entry stores the counter value of its ack cycle.
- Push = hit. Pop = `out_valid & out_ready`.
- Not full: a push writes at the write pointer and increments it. Pointers wrap modulo depth.
- Full, push and pop in the same cycle: both happen. `count` stays at depth and nothing is dropped.
- Full, push, no pop, `stop_full`=1: the entry is discarded. `drops` +1.
- Full, push, no pop, `stop_full`=0: the entry overwrites the oldest slot. Both pointers advance, `count` stays at depth, `drops` +1.
- Empty, push and pop in the same cycle: pop is not possible because `out_valid`=0. The push is stored.
- `drops` saturates at 2**drop_width-1.
- `clear`: in the next cycle `count`=0 and `drops`=0, and pointers are equal. `clear` has priority over a push or pop in the same cycle. The timestamp counter is not affected.
- `out_valid` = (`count` != 0). `out_*` show the entry at the read pointer.

## Timing
- Reset (`reset`=0 at a clk edge): `count`=0, `drops`=0, timestamp=0, pointers=0, `out_valid`=0. `out_adr`/`out_dat`/`out_we`/`out_ts` are don't-care while `out_valid`=0. Memory contents are not reset.
- Reset mid-operation discards all entries. Reset overrides `clear`, push and pop.
- Capture latency: a hit at edge N is visible on `out_*`, with `out_valid`=1 and `count` updated, after edge N. The FIFO holds one entry per ack cycle, so back-to-back acks give back-to-back entries with no gaps.
- Pop: `out_ready` is sampled at the edge. The next entry, or `out_valid`=0, appears after that edge. Full throughput is 1 entry per clk.
- `out_*` must hold stable while `out_valid`=1 and `out_ready`=0. The exception is overwrite mode when full, where the head advances on a push.
- Config inputs (`filt_*`, `enable`, `stop_full`) are sampled in the same cycle as `mon_ack`.

## Test plan
- Reset, then 3 write acks to 0x0000_1000/1004/1008, data 0xA/0xB/0xC, filter mask 0, `out_ready`=0: `count`=3 and the head is adr 0x1000, dat 0xA, we=1. Drain with `out_ready`=1 → 3 consecutive cycles in order, then `out_valid`=0.
- `filt_base`=0x4000_0000, `filt_mask`=0xF000_0000, `filt_mode`=01: a read at 0x4000_0010 is captured. A write to the same address and a read at 0x0000_0010 are not. `count`=1.
- Depth 16, `stop_full`=1, 20 acks with data 0..19, no pop: `count`=16, `drops`=4, and the drained data is 0..15.
- Same with `stop_full`=0: `drops`=4 and the drained data is 4..19. Then 300 more acks with no pop (`drop_width`=8): `drops`=255, saturated.
- Full FIFO with push and pop in the same cycle for 5 cycles: `count`=16 and `drops`=0 throughout. `clear` together with a hit → next cycle `count`=0, `drops`=0.
- Timestamps of acks 3 clk apart differ by exactly 3. Wrap check with `ts_width`=4: after 0xF comes 0x0. Assert `reset`=0 with `count`=5 → next cycle `count`=0 and `out_valid`=0.
